// File: rtl/warp_scheduler.sv
// Batch controller: gathers BATCH packed elements, time-multiplexes them over a LANES-wide kernel pool, returns results.
// Optional WARP_SCHED_PERF_EN adds exec_cycles, the ISSUE+WAIT cycle count of the last completed batch.
module warp_scheduler #(
  parameter int BATCH = 512,
  parameter int LANES = 64,
  parameter int DW    = 16
) (
  input  logic                  bus_clk,
  input  logic                  srst,
  input  logic                  run_en,
  output logic                  recv_rden,
  input  logic                  recv_empty,
  input  logic [31:0]           recv_data,
  input  logic                  recv_valid,
  output logic [LANES*DW-1:0]   lane_data,
  output logic                  lane_valid,
  input  logic [LANES*DW-1:0]   lane_result,
  input  logic                  lane_done,
  output logic                  send_wren,
  output logic [31:0]           send_data,
  input  logic                  send_full,
  output logic [3:0]            state_led,
  output logic [15:0]           batch_count
`ifdef WARP_SCHED_PERF_EN
  ,
  output logic [31:0]           exec_cycles
`endif
);

  localparam int HALF  = BATCH / 2;
  localparam int NPASS = BATCH / LANES;
  localparam int CW    = $clog2(HALF) + 1;
  localparam int IW    = $clog2(BATCH);
  localparam logic [CW-1:0] HALF_C    = CW'(HALF);
  localparam logic [CW-1:0] LAST_WORD = CW'(HALF - 1);
  localparam logic [CW-1:0] LAST_PASS = CW'(NPASS - 1);

  typedef enum logic [2:0] {IDLE, RECV, ISSUE, WAIT, SEND} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        issued_q, issued_d;
  logic [CW-1:0]        r_q, r_d;
  logic [CW-1:0]        p_q, p_d;
  logic [CW-1:0]        s_q, s_d;
  logic [15:0]          batch_count_q, batch_count_d;
  logic [3:0]           state_led_q, state_led_d;
  logic                 lane_valid_q, lane_valid_d;
  logic [LANES*DW-1:0]  lane_data_q, lane_data_d;

  logic [DW-1:0]        in_buf  [BATCH];
  logic [DW-1:0]        out_buf [BATCH];

  logic                 in_wr, out_wr;
  logic [IW-1:0]        r_lo_idx, s_lo_idx, p_base, lane_idx;

  assign r_lo_idx = IW'({r_q, 1'b0});
  assign s_lo_idx = IW'({s_q, 1'b0});
  assign p_base   = IW'(p_q * LANES);

  assign recv_rden = (state_q == RECV) && !recv_empty && (issued_q < HALF_C);
  assign send_wren = (state_q == SEND) && !send_full && (s_q < HALF_C);
  assign send_data = {out_buf[s_lo_idx | IW'(1)], out_buf[s_lo_idx]};

  assign lane_data   = lane_data_q;
  assign lane_valid  = lane_valid_q;
  assign state_led   = state_led_q;
  assign batch_count = batch_count_q;

  always_comb begin
    state_d       = state_q;
    issued_d      = issued_q;
    r_d           = r_q;
    p_d           = p_q;
    s_d           = s_q;
    batch_count_d = batch_count_q;
    lane_data_d   = lane_data_q;
    in_wr         = 1'b0;
    out_wr        = 1'b0;
    lane_idx      = '0;

    if (!run_en) begin
      state_d  = IDLE;
      issued_d = '0;
      r_d      = '0;
      p_d      = '0;
      s_d      = '0;
    end else begin
      case (state_q)
        IDLE: state_d = RECV;
        RECV: begin
          if (recv_rden) issued_d = issued_q + CW'(1);
          if (recv_valid) begin
            in_wr = 1'b1;
            r_d   = r_q + CW'(1);
            if (r_q == LAST_WORD) state_d = ISSUE;
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (lane_done) begin
            out_wr = 1'b1;
            if (p_q == LAST_PASS) begin
              state_d = SEND;
              p_d     = '0;
            end else begin
              state_d = ISSUE;
              p_d     = p_q + CW'(1);
            end
          end
        end
        SEND: begin
          if (send_wren) begin
            s_d = s_q + CW'(1);
            if (s_q == LAST_WORD) begin
              state_d       = IDLE;
              batch_count_d = batch_count_q + 16'd1;
              issued_d      = '0;
              r_d           = '0;
              s_d           = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // The word landing on the RECV->ISSUE edge is not in in_buf yet, so forward it.
    if (state_d == ISSUE) begin
      for (int i = 0; i < LANES; i++) begin
        lane_idx = IW'(p_d * LANES + i);
        lane_data_d[i*DW +: DW] = in_buf[lane_idx];
        if (in_wr && (CW'(lane_idx >> 1) == r_q))
          lane_data_d[i*DW +: DW] = lane_idx[0] ? recv_data[31:16] : recv_data[15:0];
      end
    end

    lane_valid_d = (state_d == ISSUE);
    case (state_d)
      IDLE:        state_led_d = 4'b0001;
      RECV:        state_led_d = 4'b0010;
      ISSUE, WAIT: state_led_d = 4'b0100;
      default:     state_led_d = 4'b1000;
    endcase
  end

  always_ff @(posedge bus_clk) begin
    if (srst) begin
      state_q       <= IDLE;
      issued_q      <= '0;
      r_q           <= '0;
      p_q           <= '0;
      s_q           <= '0;
      batch_count_q <= '0;
      state_led_q   <= 4'b0001;
      lane_valid_q  <= 1'b0;
      lane_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      issued_q      <= issued_d;
      r_q           <= r_d;
      p_q           <= p_d;
      s_q           <= s_d;
      batch_count_q <= batch_count_d;
      state_led_q   <= state_led_d;
      lane_valid_q  <= lane_valid_d;
      lane_data_q   <= lane_data_d;
    end
  end

  // Buffer storage carries no reset; contents only matter once filled.
  always_ff @(posedge bus_clk) begin
    if (in_wr) begin
      in_buf[r_lo_idx]           <= recv_data[15:0];
      in_buf[r_lo_idx | IW'(1)]  <= recv_data[31:16];
    end
    if (out_wr) begin
      for (int i = 0; i < LANES; i++)
        out_buf[p_base + IW'(i)] <= lane_result[i*DW +: DW];
    end
  end

`ifdef WARP_SCHED_PERF_EN
  logic [31:0] exec_cnt_q, exec_cnt_d;
  logic [31:0] exec_cycles_q, exec_cycles_d;

  always_comb begin
    exec_cnt_d    = exec_cnt_q;
    exec_cycles_d = exec_cycles_q;
    if (run_en) begin
      if (state_q == RECV && state_d == ISSUE)
        exec_cnt_d = '0;
      else if (state_q == ISSUE || state_q == WAIT)
        exec_cnt_d = exec_cnt_q + 32'd1;
      if (state_q == WAIT && state_d == SEND)
        exec_cycles_d = exec_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge bus_clk) begin
    if (srst) begin
      exec_cnt_q    <= '0;
      exec_cycles_q <= '0;
    end else begin
      exec_cnt_q    <= exec_cnt_d;
      exec_cycles_q <= exec_cycles_d;
    end
  end

  assign exec_cycles = exec_cycles_q;
`endif

endmodule

// File: tb/tb_warp_scheduler.sv
// Scoreboard bench for warp_scheduler with BATCH=8, LANES=4: input FIFO model, +1 lane model (latency 3), send monitor.
module tb_warp_scheduler;
  localparam int BATCH = 8;
  localparam int LANES = 4;
  localparam int DW    = 16;

  logic                 bus_clk = 1'b0;
  logic                 srst, run_en;
  logic                 recv_rden, recv_empty, recv_valid;
  logic [31:0]          recv_data;
  logic [LANES*DW-1:0]  lane_data, lane_result;
  logic                 lane_valid, lane_done;
  logic                 send_wren, send_full;
  logic [31:0]          send_data;
  logic [3:0]           state_led;
  logic [15:0]          batch_count;
`ifdef WARP_SCHED_PERF_EN
  logic [31:0]          exec_cycles;
`endif

  always #5 bus_clk = ~bus_clk;

  warp_scheduler #(.BATCH(BATCH), .LANES(LANES), .DW(DW)) dut (
    .bus_clk     (bus_clk),
    .srst        (srst),
    .run_en      (run_en),
    .recv_rden   (recv_rden),
    .recv_empty  (recv_empty),
    .recv_data   (recv_data),
    .recv_valid  (recv_valid),
    .lane_data   (lane_data),
    .lane_valid  (lane_valid),
    .lane_result (lane_result),
    .lane_done   (lane_done),
    .send_wren   (send_wren),
    .send_data   (send_data),
    .send_full   (send_full),
    .state_led   (state_led),
`ifdef WARP_SCHED_PERF_EN
    .exec_cycles (exec_cycles),
`endif
    .batch_count (batch_count)
  );

  int checks = 0;
  int errors = 0;
  int rden_cnt = 0;
  int lv_cnt = 0;
  int wr_cnt = 0;
  int full_viol = 0;
  bit gap_mode = 1'b0;
  bit gap_phase = 1'b0;
  logic [31:0] fifo_q [$];
  logic [31:0] exp_q [$];
  logic [31:0] vin  [5][4];
  logic [31:0] vexp [5][4];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // Queue one batch of input words and, unless it will be aborted, its expected output words.
  task automatic applyStimulus(input int b, input bit expect_out);
    for (int k = 0; k < 4; k++) begin
      fifo_q.push_back(vin[b][k]);
      if (expect_out) exp_q.push_back(vexp[b][k]);
    end
  endtask

  task automatic clearCounters();
    rden_cnt  = 0;
    lv_cnt    = 0;
    wr_cnt    = 0;
    full_viol = 0;
  endtask

  task automatic waitBatch(input int target);
    int n = 0;
    while (int'(batch_count) != target && n < 1000) begin
      @(negedge bus_clk);
      n++;
    end
    checkOutput("batch_count", 32'(batch_count), 32'(target));
  endtask

  // Input FIFO: rden sampled mid-cycle, data/valid presented the cycle after acceptance.
  initial begin
    bit took;
    recv_empty = 1'b1;
    recv_valid = 1'b0;
    recv_data  = '0;
    forever begin
      @(negedge bus_clk);
      took = recv_rden;
      @(posedge bus_clk);
      #1;
      recv_valid = took;
      if (took) begin
        rden_cnt++;
        if (fifo_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL fifo_underflow: got rden with 0 words expected no rden");
          recv_data = '0;
        end else begin
          recv_data = fifo_q.pop_front();
        end
      end
      gap_phase  = ~gap_phase;
      recv_empty = (fifo_q.size() == 0) || (gap_mode && gap_phase);
    end
  end

  // Lane pool: result = operand + 1, done strobe three cycles after the launch cycle.
  initial begin
    logic [LANES*DW-1:0] captured;
    lane_done   = 1'b0;
    lane_result = '0;
    forever begin
      @(negedge bus_clk);
      lane_done = 1'b0;
      if (lane_valid) begin
        lv_cnt++;
        captured = lane_data;
        repeat (3) @(negedge bus_clk);
        for (int i = 0; i < LANES; i++)
          lane_result[i*DW +: DW] = captured[i*DW +: DW] + 16'd1;
        lane_done = 1'b1;
      end
    end
  end

  // Monitor: every output word is popped against the scoreboard.
  initial begin
    forever begin
      @(negedge bus_clk);
      if (send_wren === 1'b1) begin
        wr_cnt++;
        if (send_full) full_viol++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_write: got 0x%08h expected no write", send_data);
        end else begin
          checkOutput("send_data", send_data, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int n;
    vin[0]  = '{32'h0002_0001, 32'h0004_0003, 32'h0006_0005, 32'h0008_0007};
    vexp[0] = '{32'h0003_0002, 32'h0005_0004, 32'h0007_0006, 32'h0009_0008};
    vin[1]  = '{32'h0011_0010, 32'h0013_0012, 32'h0015_0014, 32'h0017_0016};
    vexp[1] = '{32'h0012_0011, 32'h0014_0013, 32'h0016_0015, 32'h0018_0017};
    vin[2]  = '{32'h0000_FFFF, 32'h1234_ABCD, 32'h7FFF_8000, 32'h0002_0001};
    vexp[2] = '{32'h0001_0000, 32'h1235_ABCE, 32'h8000_8001, 32'h0003_0002};
    vin[3]  = '{32'h00AA_0055, 32'h00BB_0066, 32'h00CC_0077, 32'h00DD_0088};
    vexp[3] = '{32'h00AB_0056, 32'h00BC_0067, 32'h00CD_0078, 32'h00DE_0089};
    vin[4]  = vin[0];
    vexp[4] = vexp[0];

    srst      = 1'b1;
    run_en    = 1'b0;
    send_full = 1'b0;
    repeat (2) @(posedge bus_clk);
    @(negedge bus_clk);
    checkOutput("reset_state_led", 32'(state_led), 32'h1);
    checkOutput("reset_recv_rden", 32'(recv_rden), 32'h0);
    checkOutput("reset_lane_valid", 32'(lane_valid), 32'h0);
    checkOutput("reset_send_wren", 32'(send_wren), 32'h0);
    checkOutput("reset_batch_count", 32'(batch_count), 32'h0);
    @(posedge bus_clk);
    #1;
    srst = 1'b0;

    // Plain batch, inputs 1..8.
    clearCounters();
    applyStimulus(0, 1'b1);
    run_en = 1'b1;
    waitBatch(1);
    checkOutput("b1_rdens", 32'(rden_cnt), 32'd4);
    checkOutput("b1_lane_valids", 32'(lv_cnt), 32'd2);
    checkOutput("b1_writes", 32'(wr_cnt), 32'd4);
    checkOutput("b1_sb_left", 32'(exp_q.size()), 32'd0);
`ifdef WARP_SCHED_PERF_EN
    checkOutput("b1_exec_cycles", exec_cycles, 32'd8);
`endif

    // Input FIFO empty every other cycle.
    clearCounters();
    gap_mode = 1'b1;
    applyStimulus(1, 1'b1);
    waitBatch(2);
    gap_mode = 1'b0;
    checkOutput("b2_rdens", 32'(rden_cnt), 32'd4);
    checkOutput("b2_writes", 32'(wr_cnt), 32'd4);
    checkOutput("b2_sb_left", 32'(exp_q.size()), 32'd0);

    // Output FIFO full for 10 cycles after the second word.
    clearCounters();
    applyStimulus(2, 1'b1);
    n = 0;
    while (wr_cnt < 2 && n < 1000) begin
      @(negedge bus_clk);
      n++;
    end
    checkOutput("b3_reach_mid_send", 32'(wr_cnt), 32'd2);
    @(posedge bus_clk);
    #1;
    send_full = 1'b1;
    repeat (10) @(posedge bus_clk);
    #1;
    checkOutput("b3_writes_during_stall", 32'(wr_cnt), 32'd2);
    send_full = 1'b0;
    waitBatch(3);
    checkOutput("b3_wren_while_full", 32'(full_viol), 32'd0);
    checkOutput("b3_writes", 32'(wr_cnt), 32'd4);
    checkOutput("b3_sb_left", 32'(exp_q.size()), 32'd0);

    // Abort in WAIT on the same cycle as lane_done.
    clearCounters();
    applyStimulus(3, 1'b0);
    n = 0;
    do begin
      @(negedge bus_clk);
      n++;
    end while (lane_valid !== 1'b1 && n < 1000);
    checkOutput("b4_lane_launch", 32'(lane_valid), 32'h1);
    repeat (3) @(negedge bus_clk);
    run_en = 1'b0;
    @(negedge bus_clk);
    checkOutput("b4_abort_state_led", 32'(state_led), 32'h1);
    repeat (5) @(negedge bus_clk);
    checkOutput("b4_abort_writes", 32'(wr_cnt), 32'd0);
    checkOutput("b4_abort_batch_count", 32'(batch_count), 32'd3);
    checkOutput("b4_rdens", 32'(rden_cnt), 32'd4);

    // Recovery batch after abort.
    clearCounters();
    applyStimulus(4, 1'b1);
    run_en = 1'b1;
    waitBatch(4);
    checkOutput("b5_lane_valids", 32'(lv_cnt), 32'd2);
    checkOutput("b5_writes", 32'(wr_cnt), 32'd4);
    checkOutput("b5_sb_left", 32'(exp_q.size()), 32'd0);
`ifdef WARP_SCHED_PERF_EN
    checkOutput("b5_exec_cycles", exec_cycles, 32'd8);
`endif

    repeat (3) @(negedge bus_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
